// File: rtl/stage1_alu_preproc_if.sv
// Stage-1 ALU preprocessor bus: instruction handshake, memory read port and stage-2 ALU outputs.
// master = instruction/memory source side, slave = the preprocessor.
interface stage1_alu_preproc_if #(
  parameter int N = 32,
  parameter int O = 3,
  parameter int S = 5
);
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [N-1:0] src1;
  logic [N-1:0] src2;
  logic         mem_rd_req;
  logic [N-1:0] mem_addr;
  logic         mem_rd_valid;
  logic [N-1:0] mem_rd_data;
  logic [N-1:0] aluin1;
  logic [N-1:0] aluin2;
  logic [O-1:0] operation;
  logic [O-1:0] opselect;
  logic [S-1:0] shift_number;
  logic         enable_arith;
  logic         enable_shift;

  modport master (
    output instr_valid, instr, src1, src2, mem_rd_valid, mem_rd_data,
    input  instr_ready, mem_rd_req, mem_addr, aluin1, aluin2, operation, opselect,
           shift_number, enable_arith, enable_shift
  );

  modport slave (
    input  instr_valid, instr, src1, src2, mem_rd_valid, mem_rd_data,
    output instr_ready, mem_rd_req, mem_addr, aluin1, aluin2, operation, opselect,
           shift_number, enable_arith, enable_shift
  );
endinterface

// File: rtl/stage1_alu_preproc.sv
// Stage-1 ALU preprocessor: decode, LOAD operand fetch, registered ALU inputs; latency 1 cycle (LOAD: 1 + memory wait).
// instr_ready is low while waiting on memory; STAGE1_IMM_SIGN_EXT_EN sign-extends the ARITH immediate.
module stage1_alu_preproc #(
  parameter int N    = 32,
  parameter int O    = 3,
  parameter int S    = 5,
  parameter int IMMW = 16
) (
  input logic                  clock,
  input logic                  reset,
  stage1_alu_preproc_if.slave  bus
);

  typedef struct packed {
    logic [1:0]      cls;
    logic [O-1:0]    opselect;
    logic [O-1:0]    operation;
    logic            imm_sel;
    logic [1:0]      rsvd;
    logic [S-1:0]    shamt;
    logic [IMMW-1:0] imm16;
  } instr_t;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_SHIFT = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;

  state_t       state;
  instr_t       ins;
  logic         accept;
  logic [N-1:0] imm_arith;
  logic [N-1:0] imm_sext;
  logic [N-1:0] ld_src1;
  logic [O-1:0] ld_operation;
  logic [O-1:0] ld_opselect;
  logic [1:0]   unused_rsvd;

  assign ins             = instr_t'(bus.instr);
  assign unused_rsvd     = ins.rsvd;
  assign bus.instr_ready = (state == IDLE);
  assign accept          = bus.instr_valid & bus.instr_ready;
  assign imm_sext        = {{(N-IMMW){ins.imm16[IMMW-1]}}, ins.imm16};

`ifdef STAGE1_IMM_SIGN_EXT_EN
  assign imm_arith = imm_sext;
`else
  assign imm_arith = {{(N-IMMW){1'b0}}, ins.imm16};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      bus.aluin1       <= '0;
      bus.aluin2       <= '0;
      bus.operation    <= '0;
      bus.opselect     <= '0;
      bus.shift_number <= '0;
      bus.enable_arith <= 1'b0;
      bus.enable_shift <= 1'b0;
      bus.mem_rd_req   <= 1'b0;
      bus.mem_addr     <= '0;
      ld_src1          <= '0;
      ld_operation     <= '0;
      ld_opselect      <= '0;
    end else begin
      // enables are single-cycle pulses; data outputs hold unless overwritten
      bus.enable_arith <= 1'b0;
      bus.enable_shift <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (ins.cls)
              CLS_ARITH: begin
                bus.aluin1       <= bus.src1;
                bus.aluin2       <= ins.imm_sel ? imm_arith : bus.src2;
                bus.opselect     <= ins.opselect;
                bus.operation    <= ins.operation;
                bus.enable_arith <= 1'b1;
              end
              CLS_SHIFT: begin
                bus.aluin1       <= bus.src1;
                bus.aluin2       <= '0;
                bus.shift_number <= ins.imm_sel ? ins.shamt : bus.src2[S-1:0];
                bus.operation    <= ins.operation;
                bus.enable_shift <= 1'b1;
              end
              CLS_LOAD: begin
                ld_src1        <= bus.src1;
                ld_operation   <= ins.operation;
                ld_opselect    <= ins.opselect;
                bus.mem_addr   <= bus.src1 + imm_sext;
                bus.mem_rd_req <= 1'b1;
                state          <= WAIT_MEM;
              end
              default: ;
            endcase
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rd_valid) begin
            bus.aluin1       <= ld_src1;
            bus.aluin2       <= bus.mem_rd_data;
            bus.operation    <= ld_operation;
            bus.opselect     <= ld_opselect;
            bus.enable_arith <= 1'b1;
            bus.mem_rd_req   <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
